hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/hazard_scoreboard_sb_counter.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants and types for the register hazard scoreboard.
package riscv_pkg;

    localparam int unsigned REG_COUNT_DEF    = 32;
    localparam int unsigned IDX_W_DEF        = 5;
    localparam int unsigned MAX_INFLIGHT_DEF = 3;
    localparam int unsigned EXTRA_STALL_DEF  = 1;
    localparam int unsigned WB_BYPASS_DEF    = 0;

    // Hold counter covers EXTRA_STALL values 0..7.
    localparam int unsigned HOLD_W = 3;

    // Width needed to count 0..max_inflight pending writes.
    function automatic int unsigned cnt_width(input int unsigned max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_width(MAX_INFLIGHT_DEF);

    // Per-register update requests for one cycle.
    typedef struct packed {
        logic inc;
        logic dec_wb;
        logic dec_kill;
    } cnt_upd_t;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register: +1 issue, -1 writeback,
// -1 kill applied as a single net update; underflow clamps at zero and flags.
module sb_counter
    import riscv_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned MAX_VAL = MAX_INFLIGHT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  cnt_upd_t         upd,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow_c
);

    localparam int unsigned SUM_W = CNT_W + 2;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [SUM_W-1:0] up_c;
    logic [SUM_W-1:0] down_c;
    logic [SUM_W-1:0] diff_c;

    // Net update with underflow clamp and a defensive ceiling at MAX_VAL.
    always_comb begin
        underflow_c = 1'b0;
        cnt_d       = cnt_q;
        up_c        = {2'b00, cnt_q} + SUM_W'(upd.inc);
        down_c      = SUM_W'(upd.dec_wb) + SUM_W'(upd.dec_kill);
        diff_c      = '0;
        if (up_c < down_c) begin
            underflow_c = 1'b1;
            cnt_d       = '0;
        end else begin
            diff_c = up_c - down_c;
            if (diff_c > SUM_W'(MAX_VAL)) begin
                cnt_d = CNT_W'(MAX_VAL);
            end else begin
                cnt_d = CNT_W'(diff_c);
            end
        end
    end

    // Counter state; reset discards any update presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard: tracks outstanding writes per register, raises a stall
// when a true source read hits a pending register, and gates issue on counter
// capacity.
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int unsigned REG_COUNT    = REG_COUNT_DEF,
    parameter int unsigned IDX_W        = IDX_W_DEF,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    parameter int unsigned EXTRA_STALL  = EXTRA_STALL_DEF,
    parameter int unsigned WB_BYPASS    = WB_BYPASS_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     rs1,
    input  logic                 rs1_read,
    input  logic [IDX_W-1:0]     rs2,
    input  logic                 rs2_read,
    input  logic                 issue_valid,
    input  logic                 issue_regwrite,
    input  logic [IDX_W-1:0]     issue_rd,
    input  logic                 wb_valid,
    input  logic [IDX_W-1:0]     wb_rd,
    input  logic                 kill_valid,
    input  logic [IDX_W-1:0]     kill_rd,
    output logic                 stall_needed,
    output logic                 issue_ready,
    output logic [REG_COUNT-1:0] busy_mask,
    output logic                 error
);

    localparam int unsigned CNT_W    = cnt_width(MAX_INFLIGHT);
    localparam int unsigned IDX_SPAN = 1 << IDX_W;

    // Counters for every encodable index; untracked slots (0 and beyond
    // REG_COUNT-1) read as zero so source lookups never leave the array.
    logic [IDX_SPAN-1:0][CNT_W-1:0] cnt_all;
    logic [REG_COUNT-1:0]           uflow;

    logic src1_busy_c;
    logic src1_byp_c;
    logic src2_busy_c;
    logic src2_byp_c;
    logic hazard_c;
    logic rd_full_c;
    logic issue_accept_c;

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              error_q;
    logic              error_d;

    assign cnt_all[0] = '0;
    assign uflow[0]   = 1'b0;

    // One counter per tracked register.
    for (genvar i = 1; i < int'(REG_COUNT); i++) begin : g_reg
        cnt_upd_t upd;

        assign upd.inc      = issue_accept_c && issue_regwrite && (issue_rd == IDX_W'(i));
        assign upd.dec_wb   = wb_valid && (wb_rd == IDX_W'(i));
        assign upd.dec_kill = kill_valid && (kill_rd == IDX_W'(i));

        sb_counter #(
            .CNT_W   (CNT_W),
            .MAX_VAL (MAX_INFLIGHT)
        ) u_cnt (
            .clock       (clock),
            .reset       (reset),
            .upd         (upd),
            .cnt         (cnt_all[i]),
            .underflow_c (uflow[i])
        );
    end

    for (genvar j = int'(REG_COUNT); j < int'(IDX_SPAN); j++) begin : g_pad
        assign cnt_all[j] = '0;
    end

    // Source hazard detection with optional same-cycle last-writeback bypass.
    always_comb begin
        src1_busy_c = rs1_read && (rs1 != '0) && (cnt_all[rs1] != '0);
        src2_busy_c = rs2_read && (rs2 != '0) && (cnt_all[rs2] != '0);
        src1_byp_c  = (WB_BYPASS != 0) && wb_valid && (wb_rd == rs1)
                      && (cnt_all[rs1] == CNT_W'(1))
                      && !(kill_valid && (kill_rd == rs1));
        src2_byp_c  = (WB_BYPASS != 0) && wb_valid && (wb_rd == rs2)
                      && (cnt_all[rs2] == CNT_W'(1))
                      && !(kill_valid && (kill_rd == rs2));
        hazard_c    = (src1_busy_c && !src1_byp_c) || (src2_busy_c && !src2_byp_c);
    end

    // Stall, capacity gating and issue acceptance.
    always_comb begin
        stall_needed   = hazard_c || (hold_q != '0);
        rd_full_c      = issue_regwrite && (issue_rd != '0)
                         && (cnt_all[issue_rd] == CNT_W'(MAX_INFLIGHT));
        issue_ready    = !stall_needed && !rd_full_c;
        issue_accept_c = issue_valid && issue_ready;
    end

    // Next-state for the stall extension and the sticky underflow flag.
    always_comb begin
        hold_d  = hold_q;
        error_d = error_q || (|uflow);
        if (hazard_c) begin
            hold_d = HOLD_W'(EXTRA_STALL);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end
    end

    // Hold and error state.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_q  <= '0;
            error_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            error_q <= error_d;
        end
    end

    // Busy view straight from registered counters.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < int'(REG_COUNT); i++) begin
            busy_mask[i] = (cnt_all[i] != '0);
        end
    end

    assign error = error_q;

endmodule
